veririsc_core: RTL

Parametrised multi-cycle VeriRISC processor core with a configurable data and address width and a stallable request/acknowledge memory port. It replaces the fixed 8-bit, 8-phase datapath with a core that can wait on slow memory. The core also supports restart after a halt. It is the CPU block instantiated next to the program/data memory in the system top level.

---
 rtl/veririsc_core.sv | 114 +++++++++++
 1 files changed

// File: rtl/veririsc_core.sv
// veririsc_core: multi-cycle VeriRISC CPU with a stallable req/ack memory port
//
// Parameters:
//   DWIDTH    accumulator / data bus width (must be >= AWIDTH+3)
//   AWIDTH    address and program counter width
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   go        restart pulse, honoured only while halted
//   mem_req   memory transaction request (held until acked)
//   mem_we    1 = write, 0 = read; valid with mem_req
//   mem_addr  transaction address
//   mem_wdata write data (accumulator)
//   mem_rdata read data, sampled on the ack cycle
//   mem_ack   transaction completion, may coincide with the request cycle
//   halted    core sits in HALTED
//   pc        program counter (debug)
//   acc       accumulator (debug)
//   retired   instructions completed, only with VERIRISC_RETIRE_CNT_EN defined
module veririsc_core #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic [AWIDTH-1:0] pc,
   output logic [DWIDTH-1:0] acc
`ifdef VERIRISC_RETIRE_CNT_EN
   ,
   output logic [31:0]       retired
`endif
);
   localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4, OP_STO = 3'd6, OP_JMP = 3'd7;
   typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALTED} state_t;
   state_t state, state_nxt;
   logic [AWIDTH+2:0] ir, ir_nxt;
   logic [AWIDTH-1:0] pc_nxt, pc_inc, ir_addr;
   logic [DWIDTH-1:0] acc_nxt, alu;
   logic [2:0] opc;
   logic mem_op, zero;
   assign opc = ir[AWIDTH+2:AWIDTH];
   assign ir_addr = ir[AWIDTH-1:0];
   assign pc_inc = pc + AWIDTH'(1);
   assign zero = acc == '0;
   assign mem_op = opc != OP_HLT && opc != OP_SKZ && opc != OP_JMP;
   assign alu = opc == OP_ADD ? acc + mem_rdata :
                opc == OP_AND ? acc & mem_rdata :
                opc == OP_XOR ? acc ^ mem_rdata : mem_rdata;
   // Moore memory outputs; the request is masked while reset is held so an
   // in-flight transaction is dropped the instant reset asserts.
   assign mem_req = rst && (state == FETCH || (state == EXEC && mem_op));
   assign mem_we = state == EXEC && opc == OP_STO;
   assign mem_addr = state == FETCH ? pc : ir_addr;
   assign mem_wdata = acc;
   assign halted = state == HALTED;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FETCH;
         pc <= '0;
         acc <= '0;
         ir <= '0;
      end else begin
         state <= state_nxt;
         pc <= pc_nxt;
         acc <= acc_nxt;
         ir <= ir_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      pc_nxt = pc;
      acc_nxt = acc;
      ir_nxt = ir;
      case (state)
         FETCH: if (mem_ack) begin
            ir_nxt = mem_rdata[AWIDTH+2:0];
            state_nxt = DECODE;
         end
         DECODE: begin
            pc_nxt = pc_inc;
            state_nxt = opc == OP_HLT ? HALTED : EXEC;
         end
         EXEC: if (opc == OP_SKZ) begin
            pc_nxt = zero ? pc_inc : pc;
            state_nxt = FETCH;
         end else if (opc == OP_JMP) begin
            pc_nxt = ir_addr;
            state_nxt = FETCH;
         end else if (mem_ack) begin
            acc_nxt = opc == OP_STO ? acc : alu;
            state_nxt = FETCH;
         end
         HALTED: state_nxt = go ? FETCH : HALTED;
         default: state_nxt = FETCH;
      endcase
   end
`ifdef VERIRISC_RETIRE_CNT_EN
   // An instruction retires when EXEC hands back to FETCH, or when HLT halts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) retired <= '0;
      else if ((state == EXEC && state_nxt == FETCH) || (state == DECODE && state_nxt == HALTED))
         retired <= retired + 32'd1;
   end
`endif
endmodule
